// File: rtl/clint_trap_ctrl.sv
// clint_trap_ctrl: machine-mode trap/interrupt controller with CLINT timer and pipeline stall/flush arbiter
module clint_trap_ctrl #(
  parameter int XLEN = 64,
  parameter int NUM_STAGES = 6,
  parameter int MEM_IDX = 4,
  parameter int TICK_DIV = 1,
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [31:0]           inst_data_i,
  input  logic                  inst_valid_i,
  input  logic                  ecall_i,
  input  logic                  ebreak_i,
  input  logic                  mret_i,
  input  logic                  illegal_i,
  input  logic                  ram_stall_if_i,
  input  logic                  ram_stall_mem_i,
  input  logic                  load_use_id_i,
  input  logic                  jump_ex_i,
  input  logic [XLEN-1:0]       csr_mstatus_i,
  input  logic [XLEN-1:0]       csr_mie_i,
  input  logic [XLEN-1:0]       csr_mepc_i,
  input  logic [XLEN-1:0]       csr_mtvec_i,
  output logic [XLEN-1:0]       csr_mstatus_wdata_o,
  output logic [XLEN-1:0]       csr_mepc_wdata_o,
  output logic [XLEN-1:0]       csr_mcause_wdata_o,
  output logic [XLEN-1:0]       csr_mtval_wdata_o,
  output logic                  csr_mstatus_we_o,
  output logic                  csr_mepc_we_o,
  output logic                  csr_mcause_we_o,
  output logic                  csr_mtval_we_o,
  output logic [XLEN-1:0]       mip_o,
  output logic [XLEN-1:0]       clint_pc_o,
  output logic                  clint_pc_valid_o,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  halt_o,
  input  logic                  mmio_req_i,
  input  logic                  mmio_we_i,
  input  logic [31:0]           mmio_addr_i,
  input  logic [XLEN-1:0]       mmio_wdata_i,
  input  logic [XLEN/8-1:0]     mmio_wmask_i,
  output logic [XLEN-1:0]       mmio_rdata_o,
  output logic                  mmio_ready_o
);
  typedef enum logic [1:0] {IDLE, SETTLE, HALT} state_t;
  localparam int pw = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [NUM_STAGES-1:0] all_ones = '1;
  localparam logic [NUM_STAGES-1:0] ram_stall_mask = NUM_STAGES'((1 << MEM_IDX) - 1);
  localparam logic [NUM_STAGES-1:0] ram_flush_mask = NUM_STAGES'(1 << MEM_IDX);
  localparam logic [NUM_STAGES-1:0] trap_flush_mask = NUM_STAGES'((1 << MEM_IDX) - 2);
  localparam logic [NUM_STAGES-1:0] jump_flush_mask = NUM_STAGES'(6);
  localparam logic [NUM_STAGES-1:0] lu_stall_mask = NUM_STAGES'(3);
  localparam logic [NUM_STAGES-1:0] lu_flush_mask = NUM_STAGES'(4);
  state_t state, state_nxt;
  logic msip, mtip, tick, accept, sel_msip, sel_cmp, sel_time;
  logic [XLEN-1:0] mtime, mtimecmp, bmask, rd_val;
  logic [pw-1:0] presc;
  logic [31:0] off;
  logic ram_stall, free, msi, mti, take_int, take_ill, take_ecall, take_trap, take_ebreak, take_mret, redirect;
  logic [3:0] code;
  logic unused_mie;
  function automatic logic [XLEN-1:0] merge(input logic [XLEN-1:0] old, input logic [XLEN-1:0] wd,
                                            input logic [XLEN-1:0] m);
    return (old & ~m) | (wd & m);
  endfunction
  for (genvar b = 0; b < XLEN/8; b++) begin : g_mask
    assign bmask[8*b +: 8] = {8{mmio_wmask_i[b]}};
  end
  assign unused_mie = ^{csr_mie_i[XLEN-1:8], csr_mie_i[6:4], csr_mie_i[2:0]};
  assign mtip = mtime >= mtimecmp;
  assign tick = presc == pw'(TICK_DIV - 1);
  assign accept = mmio_req_i && !mmio_ready_o;
  assign off = mmio_addr_i - CLINT_BASE;
  assign sel_msip = off == 32'h0000;
  assign sel_cmp = off == 32'h4000;
  assign sel_time = off == 32'hBFF8;
  assign rd_val = sel_msip ? {{(XLEN-1){1'b0}}, msip} : sel_cmp ? mtimecmp : sel_time ? mtime : '0;
  assign mip_o = XLEN'({mtip, 3'b000, msip, 3'b000});
  assign ram_stall = ram_stall_if_i || ram_stall_mem_i;
  assign free = rst && state == IDLE && !ram_stall;
  assign msi = csr_mie_i[3] && msip;
  assign mti = csr_mie_i[7] && mtip;
  assign take_int = free && inst_valid_i && csr_mstatus_i[3] && (msi || mti);
  assign take_ill = free && !take_int && illegal_i;
  assign take_ecall = free && !take_int && !illegal_i && ecall_i;
  assign take_trap = take_int || take_ill || take_ecall;
  assign take_ebreak = free && !take_trap && ebreak_i;
  assign take_mret = free && !take_trap && !ebreak_i && mret_i;
  assign redirect = take_trap || take_mret;
  assign code = take_int ? (msi ? 4'd3 : 4'd7) : (illegal_i ? 4'd2 : 4'd11);
  // CLINT registers and one-shot MMIO response; an mtime write beats the tick in the same cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      msip <= 1'b0;
      mtime <= '0;
      mtimecmp <= '1;
      presc <= '0;
      mmio_ready_o <= 1'b0;
      mmio_rdata_o <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      mtime <= (accept && mmio_we_i && sel_time) ? merge(mtime, mmio_wdata_i, bmask) : mtime + XLEN'(tick);
      if (accept && mmio_we_i && sel_cmp) mtimecmp <= merge(mtimecmp, mmio_wdata_i, bmask);
      if (accept && mmio_we_i && sel_msip && mmio_wmask_i[0]) msip <= mmio_wdata_i[0];
      mmio_ready_o <= accept;
      if (accept) mmio_rdata_o <= rd_val;
    end
  // State register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // Next state: a redirect costs one SETTLE cycle, ebreak parks in HALT until reset
  always_comb
    state_nxt = state == SETTLE ? IDLE : redirect ? SETTLE : take_ebreak ? HALT : state;
  // Outputs: CSR write pulse and redirect in the take cycle, plus prioritised stall/flush masks
  always_comb begin
    halt_o = state == HALT;
    clint_pc_valid_o = redirect;
    csr_mstatus_we_o = redirect;
    csr_mepc_we_o = take_trap;
    csr_mcause_we_o = take_trap;
    csr_mtval_we_o = take_trap;
    csr_mepc_wdata_o = pc_i;
    csr_mcause_wdata_o = {take_int, {(XLEN-5){1'b0}}, code};
    csr_mtval_wdata_o = take_ill ? XLEN'(inst_data_i) : '0;
    csr_mstatus_wdata_o = csr_mstatus_i;
    csr_mstatus_wdata_o[3] = take_mret && csr_mstatus_i[7];
    csr_mstatus_wdata_o[7] = take_mret || csr_mstatus_i[3];
    csr_mstatus_wdata_o[12:11] = take_mret ? csr_mstatus_i[12:11] : 2'b11;
    clint_pc_o = take_mret ? csr_mepc_i : {csr_mtvec_i[XLEN-1:2], 2'b00} +
                 ((take_int && csr_mtvec_i[1:0] == 2'b01) ? XLEN'({code, 2'b00}) : '0);
    stall_o = !rst ? '0 : state == HALT ? all_ones : ram_stall ? ram_stall_mask :
              (redirect || jump_ex_i) ? '0 : load_use_id_i ? lu_stall_mask : '0;
    flush_o = !rst ? all_ones : state == HALT ? '0 : ram_stall ? ram_flush_mask : redirect ? trap_flush_mask :
              jump_ex_i ? jump_flush_mask : load_use_id_i ? lu_flush_mask : '0;
  end
endmodule

// File: tb/tb_clint_trap_ctrl.sv
// tb_clint_trap_ctrl: directed scenarios plus randomized traffic checked against a behavioural model
module tb_clint_trap_ctrl;
  localparam int NS = 6, MI = 4, TD = 1;
  localparam logic [31:0] BASE = 32'h0200_0000;
  logic clk = 0, rst = 0;
  logic [63:0] pc, mst, mie, mepc, mtvec, mwdata;
  logic [31:0] inst, maddr;
  logic valid, ecall, ebreak, mret, illegal, ifs, mems, lu, jump, mreq, mwe;
  logic [7:0] mmask;
  logic [63:0] mst_wd, mepc_wd, mcause_wd, mtval_wd, mip, cpc, rdata;
  logic mst_we, mepc_we, mcause_we, mtval_we, cpcv, halt, ready;
  logic [NS-1:0] stall, flush;
  int checks = 0, fails = 0;
  bit m_msip, m_ready;
  logic [63:0] m_mtime, m_cmp, m_rdata;
  int m_presc, m_mode, code;
  bit e_int, e_trap, e_ret, e_hlt;
  logic [63:0] e_cause, e_mtval, e_mst, e_pc, e_mip, e_stall, e_flush;
  logic [31:0] offs [4] = '{32'h0, 32'h4000, 32'hBFF8, 32'h1000};

  clint_trap_ctrl dut (
    .clk(clk), .rst(rst), .pc_i(pc), .inst_data_i(inst), .inst_valid_i(valid),
    .ecall_i(ecall), .ebreak_i(ebreak), .mret_i(mret), .illegal_i(illegal),
    .ram_stall_if_i(ifs), .ram_stall_mem_i(mems), .load_use_id_i(lu), .jump_ex_i(jump),
    .csr_mstatus_i(mst), .csr_mie_i(mie), .csr_mepc_i(mepc), .csr_mtvec_i(mtvec),
    .csr_mstatus_wdata_o(mst_wd), .csr_mepc_wdata_o(mepc_wd), .csr_mcause_wdata_o(mcause_wd),
    .csr_mtval_wdata_o(mtval_wd), .csr_mstatus_we_o(mst_we), .csr_mepc_we_o(mepc_we),
    .csr_mcause_we_o(mcause_we), .csr_mtval_we_o(mtval_we), .mip_o(mip), .clint_pc_o(cpc),
    .clint_pc_valid_o(cpcv), .stall_o(stall), .flush_o(flush), .halt_o(halt),
    .mmio_req_i(mreq), .mmio_we_i(mwe), .mmio_addr_i(maddr), .mmio_wdata_i(mwdata),
    .mmio_wmask_i(mmask), .mmio_rdata_o(rdata), .mmio_ready_o(ready));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] wr(input logic [63:0] old);
    for (int b = 0; b < 8; b++) if (mmask[b]) old[8*b +: 8] = mwdata[8*b +: 8];
    return old;
  endfunction

  task automatic m_reset();
    m_msip = 0; m_mtime = 0; m_cmp = '1; m_presc = 0; m_ready = 0; m_rdata = 0; m_mode = 0;
  endtask

  task automatic predict();
    bit mtip, msi, mti, free;
    mtip = m_mtime >= m_cmp;
    msi = mie[3] && m_msip;
    mti = mie[7] && mtip;
    free = m_mode == 0 && !ifs && !mems;
    e_int = free && valid && mst[3] && (msi || mti);
    e_trap = e_int || (free && (illegal || ecall));
    e_ret = free && !e_trap && !ebreak && mret;
    e_hlt = free && !e_trap && ebreak;
    code = msi ? 3 : 7;
    e_cause = e_int ? ((64'h1 << 63) | 64'(code)) : illegal ? 64'd2 : 64'd11;
    e_mtval = (e_int || !illegal) ? 64'd0 : {32'h0, inst};
    e_mst = mst;
    if (e_ret) begin
      e_mst[3] = mst[7]; e_mst[7] = 1;
    end else begin
      e_mst[7] = mst[3]; e_mst[3] = 0; e_mst[12:11] = 2'b11;
    end
    e_pc = e_ret ? mepc : (mtvec & ~64'h3) + ((e_int && mtvec[1:0] == 2'b01) ? 64'(4 * code) : 64'd0);
    e_mip = (64'(mtip) << 7) | (64'(m_msip) << 3);
    e_stall = 0; e_flush = 0;
    if (m_mode == 2) e_stall = (64'd1 << NS) - 1;
    else if (ifs || mems) begin e_stall = (64'd1 << MI) - 1; e_flush = 64'd1 << MI; end
    else if (e_trap || e_ret) e_flush = (64'd1 << MI) - 2;
    else if (jump) e_flush = 6;
    else if (lu) begin e_stall = 3; e_flush = 4; end
  endtask

  task automatic check_model();
    predict();
    chk("mip", mip, e_mip);
    chk("stall", 64'(stall), e_stall);
    chk("flush", 64'(flush), e_flush);
    chk("halt", 64'(halt), 64'(m_mode == 2));
    chk("pc_valid", 64'(cpcv), 64'(e_trap || e_ret));
    chk("mstatus_we", 64'(mst_we), 64'(e_trap || e_ret));
    chk("mepc_we", 64'(mepc_we), 64'(e_trap));
    chk("mcause_we", 64'(mcause_we), 64'(e_trap));
    chk("mtval_we", 64'(mtval_we), 64'(e_trap));
    if (e_trap || e_ret) begin
      chk("target", cpc, e_pc);
      chk("mstatus_wd", mst_wd, e_mst);
    end
    if (e_trap) begin
      chk("mepc_wd", mepc_wd, pc);
      chk("mcause_wd", mcause_wd, e_cause);
      chk("mtval_wd", mtval_wd, e_mtval);
    end
    chk("mmio_ready", 64'(ready), 64'(m_ready));
    if (m_ready) chk("mmio_rdata", rdata, m_rdata);
  endtask

  task automatic step();
    logic [31:0] off;
    bit acc, tick;
    predict();
    if (m_mode == 1) m_mode = 0;
    else if (m_mode == 0 && (e_trap || e_ret)) m_mode = 1;
    else if (m_mode == 0 && e_hlt) m_mode = 2;
    acc = mreq && !m_ready;
    off = maddr - BASE;
    if (acc) m_rdata = off == 0 ? 64'(m_msip) : off == 32'h4000 ? m_cmp : off == 32'hBFF8 ? m_mtime : 64'd0;
    tick = m_presc == TD - 1;
    m_presc = tick ? 0 : m_presc + 1;
    if (acc && mwe && off == 32'hBFF8) m_mtime = wr(m_mtime);
    else if (tick) m_mtime = m_mtime + 1;
    if (acc && mwe && off == 32'h4000) m_cmp = wr(m_cmp);
    if (acc && mwe && off == 0 && mmask[0]) m_msip = mwdata[0];
    m_ready = acc;
  endtask

  task automatic half1();
    @(negedge clk);
    check_model();
  endtask

  task automatic half2();
    @(posedge clk);
    step();
    #1;
  endtask

  task automatic cyc();
    half1();
    half2();
  endtask

  task automatic idle_in();
    valid = 0; ecall = 0; ebreak = 0; mret = 0; illegal = 0;
    ifs = 0; mems = 0; lu = 0; jump = 0; mreq = 0; mwe = 0;
    mst = 0; mie = 0; mtvec = 0; mepc = 0; pc = 0; inst = 0;
    maddr = BASE; mwdata = 0; mmask = 0;
  endtask

  task automatic mmio_wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    mreq = 1; mwe = 1; maddr = a; mwdata = d; mmask = m;
    cyc();
    cyc();
    mreq = 0; mwe = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    m_reset();
    valid = 1; ecall = 1; jump = 1; mreq = 1; mwe = 1; maddr = BASE; mwdata = 64'd1; mmask = 8'hFF;
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_flush", 64'(flush), 64'h3F);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_pcv", 64'(cpcv), 64'd0);
    chk("rst_we", 64'({mst_we, mepc_we, mcause_we, mtval_we}), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_mip", mip, 64'd0);
    @(posedge clk);
    #1;
    idle_in();
    rst = 1;
  endtask

  initial begin
    bit r;
    int k;
    idle_in();
    do_reset();
    // timer interrupt, vectored mtvec
    mst = 64'h8; mie = 64'h80; mtvec = 64'h8000_0001;
    mmio_wr(BASE + 32'h4000, 64'd5, 8'hFF);
    for (int i = 0; i < 20 && !(m_mtime >= m_cmp); i++) cyc();
    chk("mtip_wait", 64'(mip[7]), 64'd1);
    valid = 1; pc = 64'h8000_0040;
    half1();
    chk("mti_cause", mcause_wd, 64'h8000_0000_0000_0007);
    chk("mti_target", cpc, 64'h8000_001C);
    chk("mti_flush", 64'(flush), 64'b001110);
    half2();
    half1();
    chk("settle_pcv", 64'(cpcv), 64'd0);
    half2();
    valid = 0;
    // software beats timer, direct mode
    mmio_wr(BASE, 64'd1, 8'h01);
    mie = 64'h88; mtvec = 64'h8000_0000; valid = 1;
    half1();
    chk("msi_cause", mcause_wd, 64'h8000_0000_0000_0003);
    chk("msi_target", cpc, 64'h8000_0000);
    chk("msi_mie_clr", 64'(mst_wd[3]), 64'd0);
    half2();
    cyc();
    valid = 0;
    mmio_wr(BASE, 64'd0, 8'h01);
    // illegal instruction
    mst = 0; valid = 1; illegal = 1; inst = 32'hFFFF_FFFF; pc = 64'h8000_0100;
    half1();
    chk("ill_mepc", mepc_wd, 64'h8000_0100);
    chk("ill_cause", mcause_wd, 64'd2);
    chk("ill_mtval", mtval_wd, 64'hFFFF_FFFF);
    half2();
    illegal = 0; valid = 0;
    cyc();
    // ecall deferred by a memory stall, then mret
    mst = 64'h8; mie = 0; ecall = 1; valid = 1; mems = 1; pc = 64'h8000_0200;
    repeat (3) begin
      half1();
      chk("defer_stall", 64'(stall), 64'b001111);
      chk("defer_pcv", 64'(cpcv), 64'd0);
      half2();
    end
    mems = 0;
    half1();
    chk("ecall_pcv", 64'(cpcv), 64'd1);
    chk("ecall_cause", mcause_wd, 64'd11);
    half2();
    ecall = 0;
    cyc();
    mret = 1; mepc = 64'h8000_0200; mst = 64'h80;
    half1();
    chk("mret_pc", cpc, 64'h8000_0200);
    chk("mret_mie", 64'(mst_wd[3]), 64'd1);
    half2();
    mret = 0; valid = 0;
    cyc();
    // mtime wrap after a full-width write
    mreq = 1; mwe = 1; maddr = BASE + 32'hBFF8; mwdata = '1; mmask = 8'hFF;
    cyc();
    chk("mtime_wr_ready", 64'(ready), 64'd1);
    cyc();
    mwe = 0;
    cyc();
    chk("mtime_wrap_rd", rdata, 64'd0);
    cyc();
    mreq = 0;
    // randomized traffic with a reset in the middle
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      valid = $urandom_range(0, 3) != 0;
      k = valid ? $urandom_range(0, 9) : 9;
      illegal = k == 0; ecall = k == 1; mret = k == 2;
      ifs = $urandom_range(0, 7) == 0; mems = $urandom_range(0, 7) == 0;
      jump = $urandom_range(0, 3) == 0; lu = $urandom_range(0, 3) == 0;
      mst = {$urandom, $urandom}; mie = {$urandom, $urandom}; mtvec = {$urandom, $urandom};
      mepc = {$urandom, $urandom}; pc = {$urandom, $urandom}; inst = $urandom;
      if (!mreq && $urandom_range(0, 2) == 0) begin
        mreq = 1; mwe = $urandom_range(0, 1) == 1; maddr = BASE + offs[$urandom_range(0, 3)];
        mwdata = $urandom_range(0, 1) == 1 ? 64'($urandom_range(0, 800)) : {$urandom, $urandom};
        mmask = 8'($urandom);
      end
      r = m_ready;
      cyc();
      if (r) mreq = 0;
    end
    // halt on ebreak, left only by reset
    idle_in();
    cyc();
    ebreak = 1; valid = 1;
    cyc();
    ebreak = 0; ecall = 1;
    repeat (3) begin
      half1();
      chk("halt_on", 64'(halt), 64'd1);
      chk("halt_stall", 64'(stall), 64'h3F);
      chk("halt_flush", 64'(flush), 64'd0);
      half2();
    end
    do_reset();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
